// File: rtl/corelet_seq.sv
// corelet_seq: tile sequencer that drives weight load, drain, execute and OFIFO
// readout for a row x col PE array. Optional zero-row statistics: CORELET_SEQ_ZSTAT_EN.
module corelet_seq #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int bw      = 4,
   parameter int max_len = 64,
   parameter int cnt_w   = $clog2(max_len + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic                reuse_w,
   input  logic                acc_mode,
   input  logic [cnt_w-1:0]    num_vec,
   input  logic                l0_valid,
   input  logic [bw*row-1:0]   l0_rdata,
   input  logic                ofifo_valid,
   output logic                l0_rd,
   output logic [2:0]          inst_w,
   output logic                ofifo_rd,
   output logic                sfp_acc,
   output logic                busy,
   output logic                done,
   output logic [cnt_w-1:0]    zero_cnt
);

   typedef enum logic [2:0] {IDLE, WLOAD, WDRAIN, EXEC, READ, DONE} state_t;

   // One shared counter covers load reads, drain cycles and vector counts.
   localparam int ctr_w = $clog2(max_len + row + col + 1);

   state_t             state, state_nx;
   logic [ctr_w-1:0]   ctr, ctr_nx;
   logic [cnt_w-1:0]   nv_q;
   logic               acc_q;
   logic [ctr_w-1:0]   nv_ext;
   logic               nv_zero;
   logic               accept;

   assign nv_ext  = ctr_w'(nv_q);
   assign nv_zero = (nv_q == '0);
   assign accept  = (state == IDLE) && start;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ctr   <= '0;
         nv_q  <= '0;
         acc_q <= 1'b0;
      end else begin
         state <= state_nx;
         ctr   <= ctr_nx;
         if (accept) begin
            nv_q  <= (num_vec > cnt_w'(max_len)) ? cnt_w'(max_len) : num_vec;
            acc_q <= acc_mode;
         end
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_nx = state;
      ctr_nx   = ctr;
      l0_rd    = 1'b0;
      inst_w   = 3'b000;
      ofifo_rd = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               ctr_nx = '0;
               if (!reuse_w)           state_nx = WLOAD;
               else if (num_vec == '0) state_nx = READ;
               else                    state_nx = EXEC;
            end
         end
         WLOAD: begin
            l0_rd  = l0_valid;
            inst_w = l0_valid ? 3'b001 : 3'b000;
            if (l0_valid) begin
               if (ctr == ctr_w'(col - 1)) begin
                  ctr_nx   = '0;
                  state_nx = WDRAIN;
               end else begin
                  ctr_nx = ctr + ctr_w'(1);
               end
            end
         end
         WDRAIN: begin
            if (ctr == ctr_w'(row + col - 1)) begin
               ctr_nx   = '0;
               state_nx = nv_zero ? DONE : EXEC;
            end else begin
               ctr_nx = ctr + ctr_w'(1);
            end
         end
         EXEC: begin
            l0_rd  = l0_valid;
            inst_w = l0_valid ? 3'b010 : 3'b000;
            if (l0_valid) begin
               if (ctr + ctr_w'(1) == nv_ext) begin
                  ctr_nx   = '0;
                  state_nx = READ;
               end else begin
                  ctr_nx = ctr + ctr_w'(1);
               end
            end
         end
         READ: begin
            // An empty tile reaches READ only via reuse; it must not pop the OFIFO.
            if (nv_zero) begin
               state_nx = DONE;
            end else begin
               ofifo_rd = ofifo_valid;
               if (ofifo_valid) begin
                  if (ctr + ctr_w'(1) == nv_ext) begin
                     ctr_nx   = '0;
                     state_nx = DONE;
                  end else begin
                     ctr_nx = ctr + ctr_w'(1);
                  end
               end
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      if (abort && state != IDLE) begin
         state_nx = IDLE;
         ctr_nx   = '0;
         l0_rd    = 1'b0;
         inst_w   = 3'b000;
         ofifo_rd = 1'b0;
         done     = 1'b0;
      end
   end

   assign busy    = (state != IDLE);
   assign sfp_acc = acc_q & ofifo_rd;

`ifdef CORELET_SEQ_ZSTAT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         zero_cnt <= '0;
      end else if (accept) begin
         zero_cnt <= '0;
      end else if (state == EXEC && l0_rd && l0_rdata == '0 &&
                   zero_cnt < cnt_w'(max_len)) begin
         zero_cnt <= zero_cnt + cnt_w'(1);
      end
   end
`else
   wire unused_rdata = ^l0_rdata;
   assign zero_cnt = '0;
`endif

endmodule
